// File: rtl/buffer_encode.sv
// ---------------------------------------------------------------------------
// buffer_encode
//   Turns an unsigned binary value into a fixed-width ASCII decimal string.
//   Each digit occupies one byte, and the most significant digit sits in the
//   top byte. The conversion is a sequential double-dabble engine: one
//   shift-add-3 iteration per clock, followed by a single LOAD cycle that
//   registers the formatted result.
//
//   Values above 10^DIGITS-1 saturate to all '9' and raise overflow.
//
//   Optional build macro BUFFER_ENCODE_LEADING_BLANK_EN:
//     When it is defined, leading zero digits are shown as spaces (8'h20).
//     Digit 0 is never blanked, and a saturated result is never blanked.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   value        in   binary value to encode (IN_WIDTH bits)
//   in_valid     in   value is presented
//   in_ready     out  block is idle and can accept a value
//   buffer       out  ASCII digits; digit k occupies bits [8k+7:8k]
//   buffer_valid out  buffer holds a completed result
//   buffer_ready in   consumer accepts the buffer
//   overflow     out  the current result was saturated (valid with buffer_valid)
// ---------------------------------------------------------------------------
module buffer_encode #(
  parameter int IN_WIDTH = 18,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*DIGITS-1:0]   buffer,
  output logic                  buffer_valid,
  input  logic                  buffer_ready,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int CMP_W = (IN_WIDTH > 64) ? IN_WIDTH : 64;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0]      MAX_VAL   = pow10(DIGITS) - 64'd1;
  localparam logic [CMP_W-1:0] MAX_VAL_C = CMP_W'(MAX_VAL);

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return r;
  endfunction

  // BCD to ASCII, with optional leading-blank and saturation override.
  function automatic logic [8*DIGITS-1:0] fmt(input logic [BCD_W-1:0] bcd,
                                              input logic             ovf);
    logic [8*DIGITS-1:0] r;
`ifdef BUFFER_ENCODE_LEADING_BLANK_EN
    logic lead;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      r[8*k +: 8] = 8'h30 + {4'h0, bcd[4*k +: 4]};
    end
`ifdef BUFFER_ENCODE_LEADING_BLANK_EN
    // Walk down from the top digit and blank zeros until the first nonzero digit.
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (bcd[4*k +: 4] == 4'd0)) begin
        r[8*k +: 8] = 8'h20;
      end else begin
        lead = 1'b0;
      end
    end
`endif
    if (ovf) begin
      r = {DIGITS{8'h39}};
    end else begin
      r = r;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [8*DIGITS-1:0]   buffer_q, buffer_d;
  logic                  buffer_valid_q, buffer_valid_d;
  logic                  overflow_q, overflow_d;
  logic [BCD_W+IN_WIDTH-1:0] shift_s;
  logic                  in_ready_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_CONV;
        end
      end
      S_LOAD: state_d = S_DONE;
      S_DONE: begin
        if (buffer_valid_q && buffer_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the block accepts a value only while idle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Datapath next-state: capture, iterate, format, release.
  always_comb begin
    cnt_d          = cnt_q;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    ovf_d          = ovf_q;
    buffer_d       = buffer_q;
    buffer_valid_d = buffer_valid_q;
    overflow_d     = overflow_q;
    shift_s        = {add3(bcd_q), bin_q} << 1;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_s) begin
          bin_d = value;
          bcd_d = '0;
          cnt_d = CNT_W'(IN_WIDTH);
          ovf_d = (CMP_W'(value) > MAX_VAL_C);
        end else begin
          bin_d = bin_q;
        end
      end
      S_CONV: begin
        // Bits pushed out of the BCD top are lost; that only happens when ovf is set.
        bcd_d = shift_s[BCD_W+IN_WIDTH-1:IN_WIDTH];
        bin_d = shift_s[IN_WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_LOAD: begin
        buffer_d       = fmt(bcd_q, ovf_q);
        overflow_d     = ovf_q;
        buffer_valid_d = 1'b1;
      end
      S_DONE: begin
        if (buffer_valid_q && buffer_ready) begin
          buffer_valid_d = 1'b0;
          overflow_d     = 1'b0;
        end else begin
          buffer_valid_d = buffer_valid_q;
        end
      end
      default: begin
        buffer_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      bin_q          <= '0;
      bcd_q          <= '0;
      ovf_q          <= 1'b0;
      buffer_q       <= '0;
      buffer_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bin_q          <= bin_d;
      bcd_q          <= bcd_d;
      ovf_q          <= ovf_d;
      buffer_q       <= buffer_d;
      buffer_valid_q <= buffer_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign buffer       = buffer_q;
  assign buffer_valid = buffer_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_buffer_encode.sv
// Scoreboard bench for buffer_encode. The driver pushes the hand-computed
// expected result when a value is accepted. The monitor pops and compares
// whenever a new result appears on the output.
module tb_buffer_encode;
  localparam int LAT = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] value;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] buffer;
  logic        buffer_valid;
  logic        buffer_ready;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] exp_buf;
    logic        exp_ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_v = 1'b0;

`ifdef BUFFER_ENCODE_LEADING_BLANK_EN
  localparam logic [31:0] E_0  = 32'h20202030;
  localparam logic [31:0] E_7  = 32'h20202037;
  localparam logic [31:0] E_42 = 32'h20203432;
`else
  localparam logic [31:0] E_0  = 32'h30303030;
  localparam logic [31:0] E_7  = 32'h30303037;
  localparam logic [31:0] E_42 = 32'h30303432;
`endif

  buffer_encode #(.IN_WIDTH(18), .DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .value        (value),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .buffer       (buffer),
    .buffer_valid (buffer_valid),
    .buffer_ready (buffer_ready),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: compare each new result against the scoreboard head.
  always @(negedge clk) begin
    if (buffer_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", buffer);
      end else begin
        mon_e = sb.pop_front();
        chk("buffer", 64'(buffer), 64'(mon_e.exp_buf));
        chk("overflow", 64'(overflow), 64'(mon_e.exp_ovf));
        chk("latency", 64'(cyc - mon_e.acc), 64'(LAT));
      end
    end
    prev_v <= buffer_valid;
  end

  task automatic send(input logic [17:0] v, input logic [31:0] eb, input logic eo);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
      return;
    end
    value    = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.exp_buf = eb;
    e.exp_ovf = eo;
    e.acc     = cyc;
    sb.push_back(e);
    in_valid  = 1'b0;
    value     = 18'h3ffff;
  endtask

  task automatic finish_out();
    int n;
    n = 0;
    while (!buffer_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!buffer_valid) begin
      fail_now("valid_timeout");
      return;
    end
    @(posedge clk);
    #2;
    chk("valid_drop", 64'(buffer_valid), 64'(0));
    chk("in_ready_back", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] held;
    rst          = 1'b1;
    value        = 18'd0;
    in_valid     = 1'b0;
    buffer_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_buffer", 64'(buffer), 64'(0));
    chk("rst_valid", 64'(buffer_valid), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed conversions.
    send(18'd1234, 32'h31323334, 1'b0);   finish_out();
    send(18'd0, E_0, 1'b0);               finish_out();
    send(18'd7, E_7, 1'b0);               finish_out();
    send(18'd9999, 32'h39393939, 1'b0);   finish_out();
    send(18'd10000, 32'h39393939, 1'b1);  finish_out();
    send(18'd262143, 32'h39393939, 1'b1); finish_out();

    // Output stall: the result is held, and a new value is refused.
    buffer_ready = 1'b0;
    send(18'd9876, 32'h39383736, 1'b0);
    n = 0;
    while (!buffer_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!buffer_valid) fail_now("stall_valid_timeout");
    held = buffer;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_buffer", 64'(buffer), 64'(held));
      chk("stall_valid", 64'(buffer_valid), 64'(1));
      chk("stall_overflow", 64'(overflow), 64'(0));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      if (i == 1) begin
        value    = 18'd42;
        in_valid = 1'b1;
      end
    end
    in_valid     = 1'b0;
    buffer_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("stall_release", 64'(buffer_valid), 64'(0));
    chk("stall_in_ready_back", 64'(in_ready), 64'(1));
    send(18'd42, E_42, 1'b0); finish_out();

    // Asynchronous reset in the middle of a conversion.
    value    = 18'd5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_buffer", 64'(buffer), 64'(0));
    chk("abort_valid", 64'(buffer_valid), 64'(0));
    chk("abort_overflow", 64'(overflow), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (buffer_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 64'(seen), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    send(18'd5678, 32'h35363738, 1'b0); finish_out();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
